apb_sl_tx_fifo: RTL and testbench

- APB4 slave and next-generation bridge register block: a parametrised small register map plus a TX data FIFO drained by a valid/ready stream.
- APB writes to the DATA register push words into the FIFO; the stream side pops them when enabled.
- Full-FIFO handling is selectable at run time: stall the APB with bounded wait states, or drop the word and error.
- Sits between the APB interconnect and a downstream serial-link transmitter; single clock domain.

---
 rtl/apb_sl_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/apb_sl_tx_fifo.sv | 173 +++++++++++++++++
 tb/tb_apb_sl_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_sl_pkg.sv
// Shared register-map offsets, CONFIG/STATUS bit positions and the APB decode type
// for the APB TX FIFO slave.
package apb_sl_pkg;

  localparam int unsigned OFF_DATA   = 0;
  localparam int unsigned OFF_CONFIG = 1;
  localparam int unsigned OFF_STATUS = 2;
  localparam int unsigned OFF_LEVEL  = 3;

  localparam int unsigned CFG_ENABLE = 0;
  localparam int unsigned CFG_STALL  = 1;
  localparam int unsigned CFG_FLUSH  = 2;

  localparam int unsigned ST_EMPTY    = 0;
  localparam int unsigned ST_FULL     = 1;
  localparam int unsigned ST_OVERFLOW = 2;
  localparam int unsigned ST_SLVERR   = 3;

  typedef enum logic [2:0] {
    DEC_NONE,
    DEC_DATA,
    DEC_CONFIG,
    DEC_STATUS,
    DEC_LEVEL,
    DEC_BAD
  } apb_dec_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output, occupancy count and flush.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  full,
  output logic [CntW-1:0]       count
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset && do_push && !flush) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/apb_sl_tx_fifo.sv
// APB4 slave with CONFIG/STATUS/LEVEL registers feeding a TX FIFO drained by a
// valid/ready stream; full-FIFO writes either stall (bounded) or drop with error.
module apb_sl_tx_fifo
  import apb_sl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH       = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = 10'd4,
  parameter int unsigned           DATA_WIDTH       = 32,
  parameter int unsigned           FIFO_DEPTH       = 8,
  parameter int unsigned           CONFIG_REG_WIDTH = 8,
  parameter int unsigned           STALL_TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  input  logic [3:0]            pstrb,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  irq
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CntW = $clog2(STALL_TIMEOUT + 1);

  logic [CONFIG_REG_WIDTH-1:0] cfg_q, cfg_d, cfg_wmask;
  logic                        ovf_q, ovf_d, slv_q, slv_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]         addr_off;
  apb_dec_e                    dec;
  logic                        fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full, drop;
  logic [LvlW-1:0]             fifo_count;
  logic [31:0]                 rd_data;
  logic [3:0]                  status;

  // Extra MSB makes addresses below BASE_ADDR wrap to a large offset.
  assign addr_off = {1'b0, paddr} - {1'b0, BASE_ADDR};

  always_comb begin
    dec = DEC_NONE;
    if (psel && penable) begin
      if (addr_off >= (ADDR_WIDTH + 1)'(4)) begin
        dec = DEC_BAD;
      end else begin
        unique case (addr_off[1:0])
          2'(OFF_DATA):   dec = DEC_DATA;
          2'(OFF_CONFIG): dec = DEC_CONFIG;
          2'(OFF_STATUS): dec = DEC_STATUS;
          2'(OFF_LEVEL):  dec = DEC_LEVEL;
          default:        dec = DEC_BAD;
        endcase
      end
    end
  end

  assign m_valid  = cfg_q[CFG_ENABLE] & ~fifo_empty;
  assign fifo_pop = m_valid & m_ready;
  assign irq      = ovf_q | slv_q;

  always_comb begin
    for (int i = 0; i < int'(CONFIG_REG_WIDTH); i++) cfg_wmask[i] = pstrb[i / 8];
    status              = '0;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_FULL]     = fifo_full;
    status[ST_OVERFLOW] = ovf_q;
    status[ST_SLVERR]   = slv_q;
  end

  always_comb begin
    pready     = 1'b0;
    pslverr    = 1'b0;
    rd_data    = '0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    drop       = 1'b0;
    cfg_d      = cfg_q;
    ovf_d      = ovf_q;
    slv_d      = slv_q;
    cnt_d      = '0;
    unique case (dec)
      DEC_NONE: ;
      DEC_BAD: begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
      DEC_DATA: begin
        if (!pwrite) begin
          pready = 1'b1;
        end else if (pstrb != 4'hF) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end else if (!fifo_full || fifo_pop) begin
          pready    = 1'b1;
          fifo_push = 1'b1;
        end else if (!cfg_q[CFG_STALL] || cnt_q == CntW'(STALL_TIMEOUT - 1)) begin
          pready  = 1'b1;
          pslverr = 1'b1;
          drop    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEC_CONFIG: begin
        pready = 1'b1;
        if (pwrite) begin
          cfg_d            = (cfg_q & ~cfg_wmask) | (pwdata[CONFIG_REG_WIDTH-1:0] & cfg_wmask);
          cfg_d[CFG_FLUSH] = 1'b0;
          fifo_flush       = pstrb[0] & pwdata[CFG_FLUSH];
        end else begin
          rd_data = 32'(cfg_q);
        end
      end
      DEC_STATUS: begin
        pready = 1'b1;
        if (pwrite) begin
          if (pstrb[0] && pwdata[ST_OVERFLOW]) ovf_d = 1'b0;
          if (pstrb[0] && pwdata[ST_SLVERR])   slv_d = 1'b0;
        end else begin
          rd_data = 32'(status);
        end
      end
      DEC_LEVEL: begin
        pready = 1'b1;
        if (pwrite) pslverr = 1'b1;
        else        rd_data = 32'(fifo_count);
      end
      default: ;
    endcase
    // Set events override a W1C clear in the same cycle.
    if (drop)    ovf_d = 1'b1;
    if (pslverr) slv_d = 1'b1;
  end

  assign prdata = (pready && !pslverr) ? rd_data : 32'h0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      cfg_q <= '0;
      ovf_q <= 1'b0;
      slv_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      ovf_q <= ovf_d;
      slv_q <= slv_d;
      cnt_q <= cnt_d;
    end
  end

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .pclk     (pclk),
    .preset   (preset),
    .push     (fifo_push),
    .push_data(pwdata[DATA_WIDTH-1:0]),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head_data(m_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_apb_sl_tx_fifo.sv
// Scoreboard bench: the driver predicts each APB response from a queue-based model and
// queues it; independent monitors check APB completions and the stream side.
module tb_apb_sl_tx_fifo;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 8;
  localparam int unsigned TO    = 16;
  localparam logic [AW-1:0] BASE = 10'd4;

  logic          pclk = 1'b0;
  logic          preset, psel, penable, pwrite, pready, pslverr;
  logic          m_valid, m_ready, irq;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic [3:0]    pstrb;
  logic [DW-1:0] m_data;

  always #5 pclk = ~pclk;

  apb_sl_tx_fifo #(
    .ADDR_WIDTH      (AW),
    .BASE_ADDR       (BASE),
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (DEPTH),
    .CONFIG_REG_WIDTH(CW),
    .STALL_TIMEOUT   (TO)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .paddr  (paddr),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .pready (pready),
    .prdata (prdata),
    .pslverr(pslverr),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_ready(m_ready),
    .irq    (irq)
  );

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t          apb_q[$];
  logic [DW-1:0] mq[$];
  logic [CW-1:0] m_cfg;
  bit            m_ovf, m_slv;
  int            checks = 0;
  int            errors = 0;
  int            wcnt   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // APB completion monitor.
  always @(negedge pclk) begin
    exp_t e;
    if (preset) begin
      wcnt = 0;
    end else if (!(psel && penable)) begin
      wcnt = 0;
      chk("idle_pready_pslverr", {30'b0, pready, pslverr}, 32'h0);
      chk("idle_prdata", prdata, 32'h0);
    end else if (!pready) begin
      chk("wait_outputs", {31'b0, pslverr | (|prdata)}, 32'h0);
      wcnt++;
    end else begin
      if (apb_q.size() == 0) begin
        chk("apb_unexpected_done", 32'h1, 32'h0);
      end else begin
        e = apb_q.pop_front();
        chk("apb_pslverr", {31'b0, pslverr}, {31'b0, e.err});
        if (e.rd) chk("apb_prdata", prdata, e.rdata);
        chk("apb_waits", wcnt, e.waits);
      end
      wcnt = 0;
    end
  end

  // Stream side and interrupt monitor.
  always @(negedge pclk) begin
    if (!preset) begin
      chk("m_valid", {31'b0, m_valid}, {31'b0, m_cfg[0] && (mq.size() > 0)});
      chk("irq", {31'b0, irq}, {31'b0, m_ovf | m_slv});
      if (m_valid && m_ready && mq.size() > 0) chk("m_data", m_data, mq.pop_front());
    end
  end

  task automatic model_reset();
    mq.delete();
    apb_q.delete();
    m_cfg = '0;
    m_ovf = 1'b0;
    m_slv = 1'b0;
  endtask

  task automatic do_reset();
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; m_ready = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n, input int rmode);
    psel = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < n; i++) begin
      m_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge pclk);
      #1;
    end
  endtask

  // rmode: 0 m_ready low, 1 high, 2 random per cycle, 3 single pulse on access cycle k.
  task automatic xfer(input logic [AW-1:0] a, input bit wr, input logic [31:0] wd,
                      input logic [3:0] st, input int rmode, input int k);
    bit          r[TO];
    exp_t        e;
    bit          push_ok, drop, full, en, done;
    logic [AW:0] off;
    for (int i = 0; i < int'(TO); i++)
      r[i] = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) :
             (rmode == 3 && i == k);
    paddr = a; pwrite = wr; pwdata = wd; pstrb = st; psel = 1'b1; penable = 1'b0;
    m_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    m_ready = r[0];
    e.rd = !wr; e.err = 1'b0; e.rdata = '0; e.waits = 0;
    push_ok = 1'b0; drop = 1'b0;
    full = (mq.size() == DEPTH);
    en   = m_cfg[0];
    off  = {1'b0, a} - {1'b0, BASE};
    if (off >= 4) begin
      e.err = 1'b1;
    end else begin
      case (off[1:0])
        2'd0: if (wr) begin
          if (st != 4'hF) e.err = 1'b1;
          else if (!full || (en && r[0])) push_ok = 1'b1;
          else if (!m_cfg[1]) begin e.err = 1'b1; drop = 1'b1; end
          else begin
            e.err = 1'b1; drop = 1'b1; e.waits = TO - 1;
            for (int i = 0; i < int'(TO); i++) begin
              if (en && r[i]) begin
                e.err = 1'b0; drop = 1'b0; push_ok = 1'b1; e.waits = i;
                break;
              end
            end
          end
        end
        2'd1: if (!wr) e.rdata = 32'(m_cfg);
        2'd2: if (!wr) e.rdata = {28'b0, m_slv, m_ovf, full, mq.size() == 0};
        default: if (wr) e.err = 1'b1; else e.rdata = 32'(mq.size());
      endcase
    end
    apb_q.push_back(e);
    done = 1'b0;
    for (int c = 0; c < int'(TO) + 2 && !done; c++) begin
      if (c > 0) m_ready = (c < int'(TO)) ? r[c] : 1'b0;
      @(negedge pclk);
      done = pready;
      @(posedge pclk);
      #1;
    end
    psel = 1'b0;
    penable = 1'b0;
    m_ready = (rmode == 1);
    if (!done) begin
      chk("apb_timeout", 32'h0, 32'h1);
      apb_q.delete();
    end else begin
      if (push_ok) mq.push_back(wd[DW-1:0]);
      if (e.err) m_slv = 1'b1;
      if (drop) m_ovf = 1'b1;
      if (wr && off == 1 && st[0]) begin
        m_cfg = wd[CW-1:0];
        m_cfg[2] = 1'b0;
        if (wd[2]) mq.delete();
      end
      if (wr && off == 2 && st[0]) begin
        if (wd[2]) m_ovf = 1'b0;
        if (wd[3]) m_slv = 1'b0;
      end
    end
  endtask

  task automatic fill_full();
    while (mq.size() < DEPTH) xfer(BASE, 1, $urandom, 4'hF, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    logic [3:0]  st;
    logic [AW-1:0] a;
    int sel;
    do_reset();

    xfer(BASE + 2, 0, 0, 4'hF, 0, 0);          // STATUS = empty
    xfer(BASE + 3, 0, 0, 4'hF, 0, 0);          // LEVEL = 0

    xfer(BASE + 1, 1, 32'h1, 4'hF, 0, 0);
    for (int i = 0; i < 8; i++) xfer(BASE, 1, 32'hA0 + i, 4'hF, 0, 0);
    xfer(BASE + 3, 0, 0, 4'hF, 0, 0);
    xfer(BASE + 2, 0, 0, 4'hF, 0, 0);
    idle(10, 1);
    idle(2, 0);

    fill_full();
    xfer(BASE, 1, 32'hDEAD, 4'hF, 0, 0);       // dropped with error
    xfer(BASE + 2, 0, 0, 4'hF, 0, 0);
    xfer(BASE + 2, 1, 32'h4, 4'hF, 0, 0);
    xfer(BASE + 2, 0, 0, 4'hF, 0, 0);
    xfer(BASE + 2, 1, 32'h8, 4'hF, 0, 0);
    xfer(BASE + 2, 0, 0, 4'hF, 0, 0);

    xfer(BASE + 1, 1, 32'h3, 4'hF, 0, 0);
    xfer(BASE, 1, 32'h1234_5678, 4'hF, 3, 4); // pop on 5th access cycle
    xfer(BASE + 3, 0, 0, 4'hF, 0, 0);
    xfer(BASE, 1, 32'h0BAD_0BAD, 4'hF, 0, 0); // stall timeout
    xfer(BASE + 2, 1, 32'hC, 4'hF, 0, 0);

    xfer(BASE + 9, 1, 32'h0, 4'hF, 0, 0);
    xfer(BASE - 1, 0, 0, 4'hF, 0, 0);
    xfer(BASE, 1, 32'h77, 4'h3, 0, 0);
    xfer(BASE + 3, 1, 32'h0, 4'hF, 0, 0);
    xfer(BASE + 3, 0, 0, 4'hF, 0, 0);
    xfer(BASE + 1, 1, 32'hFF, 4'h0, 0, 0);
    xfer(BASE + 1, 0, 0, 4'hF, 0, 0);
    xfer(BASE, 0, 0, 4'hF, 0, 0);              // DATA reads as zero

    xfer(BASE + 1, 1, 32'h1, 4'hF, 0, 0);
    idle(3, 1);
    xfer(BASE + 3, 0, 0, 4'hF, 0, 0);          // LEVEL = 5
    xfer(BASE + 1, 1, 32'h5, 4'hF, 3, 0);      // flush with a pop in the same cycle
    xfer(BASE + 3, 0, 0, 4'hF, 0, 0);
    xfer(BASE + 1, 0, 0, 4'hF, 0, 0);

    // Reset in the middle of a stalled push.
    xfer(BASE + 1, 1, 32'h3, 4'hF, 0, 0);
    fill_full();
    paddr = BASE; pwrite = 1'b1; pwdata = 32'hCAFE; pstrb = 4'hF; psel = 1'b1;
    penable = 1'b0; m_ready = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (3) begin @(posedge pclk); #1; end
    do_reset();
    xfer(BASE + 2, 0, 0, 4'hF, 0, 0);
    xfer(BASE + 1, 0, 0, 4'hF, 0, 0);
    xfer(BASE + 3, 0, 0, 4'hF, 0, 0);
    xfer(BASE + 1, 1, 32'h3, 4'hF, 0, 0);
    fill_full();
    xfer(BASE, 1, 32'h5555, 4'hF, 0, 0);       // full timeout from a cleared counter

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      wd  = $urandom;
      st  = 4'hF;
      a   = BASE;
      if (sel < 50) begin
        if ($urandom_range(0, 15) == 0) st = 4'h3;
        xfer(a, 1, wd, st, 2, 0);
      end else if (sel < 62) begin
        wd[2] = ($urandom_range(0, 7) == 0);
        st    = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 3) != 0);
        xfer(BASE + 1, 1, wd, st, 2, 0);
      end else if (sel < 70) begin
        xfer(BASE + 2, 1, wd, 4'($urandom_range(0, 15)), 2, 0);
      end else if (sel < 95) begin
        xfer(BASE + AW'($urandom_range(0, 3)), 0, 0, 4'hF, 2, 0);
      end else begin
        xfer(AW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), wd, st, 2, 0);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 2);
    end
    idle(4, 0);
    chk("apb_queue_drained", apb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
